// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with frame-synchronous screen-mode control.
// Counters, sync/blank decode and the start/play mode are all registered; the
// decode is taken from the next counter value so it lines up with DrawX/DrawY.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       game_over,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic       start_screen
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic {StStart, StPlay} mode_e;

  logic [9:0] r_hc, r_vc;
  logic [9:0] w_hc_next, w_vc_next;
  logic       w_h_wrap, w_boundary;
  logic       r_hs, r_vs, r_blank, r_frame_start;
  logic       w_hs_next, w_vs_next, w_blank_next, w_frame_start_next;
  logic       r_start_req, r_over_req;
  logic       w_start_req_next, w_over_req_next;
  mode_e      r_mode, w_mode_next;
  logic       w_start_screen;

  // Next counter values and frame-boundary detect.
  always_comb begin
    w_h_wrap   = (r_hc == H_LAST);
    w_boundary = w_h_wrap && (r_vc == V_LAST);
    w_hc_next  = w_h_wrap ? 10'd0 : r_hc + 10'd1;
    w_vc_next  = r_vc;
    if (w_h_wrap) begin
      w_vc_next = (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
    end
  end

  // Sync/blank/frame_start decoded from the next position to stay coherent with DrawX/DrawY.
  always_comb begin
    w_hs_next          = !((w_hc_next >= HS_START) && (w_hc_next < HS_END));
    w_vs_next          = !((w_vc_next >= VS_START) && (w_vc_next < VS_END));
    w_blank_next       = (w_hc_next < H_VIS) && (w_vc_next < V_VIS);
    w_frame_start_next = w_boundary;
  end

  // Request latches: cleared on the boundary, but a request on that very clock survives.
  always_comb begin
    w_start_req_next = w_boundary ? start_btn : (r_start_req | start_btn);
    w_over_req_next  = w_boundary ? game_over : (r_over_req | game_over);
  end

  // Raster counters, decoded timing outputs and request latches.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
      r_start_req   <= 1'b0;
      r_over_req    <= 1'b0;
    end else begin
      r_hc          <= w_hc_next;
      r_vc          <= w_vc_next;
      r_hs          <= w_hs_next;
      r_vs          <= w_vs_next;
      r_blank       <= w_blank_next;
      r_frame_start <= w_frame_start_next;
      r_start_req   <= w_start_req_next;
      r_over_req    <= w_over_req_next;
    end
  end

  // Mode state register.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_mode <= StStart;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  // Mode next-state: only evaluated at the frame boundary so a frame never mixes modes.
  always_comb begin
    w_mode_next = r_mode;
    if (w_boundary) begin
      unique case (r_mode)
        StStart: if (r_start_req || start_btn) w_mode_next = StPlay;
        StPlay:  if (r_over_req || game_over)  w_mode_next = StStart;
      endcase
    end
  end

  // Mode output decode.
  always_comb begin
    w_start_screen = (r_mode == StStart);
  end

  assign DrawX        = r_hc;
  assign DrawY        = r_vc;
  assign hs           = r_hs;
  assign vs           = r_vs;
  assign blank        = r_blank;
  assign frame_start  = r_frame_start;
  assign start_screen = w_start_screen;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a shrunken raster (25 x 17) so whole frames are cheap.
// Visible 16x10; hs low for DrawX 18..21; vs low for DrawY 12..13.
module tb_vga_timing_gen;

  localparam int HT = 25;
  localparam int VT = 17;
  localparam int FRAME = HT * VT;  // 425

  logic       clk, rst, start_btn, game_over;
  logic [9:0] DrawX, DrawY;
  logic       hs, vs, blank, frame_start, start_screen;

  int n_chk = 0;
  int n_err = 0;

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .vga_clk     (clk),
    .reset       (rst),
    .start_btn   (start_btn),
    .game_over   (game_over),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .hs          (hs),
    .vs          (vs),
    .blank       (blank),
    .frame_start (frame_start),
    .start_screen(start_screen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference raster model with hand-derived decode.
  logic [9:0] m_x, m_y;
  logic       m_fs;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_x  <= '0;
      m_y  <= '0;
      m_fs <= 1'b0;
    end else begin
      m_fs <= (m_x == 10'(HT - 1)) && (m_y == 10'(VT - 1));
      if (m_x == 10'(HT - 1)) begin
        m_x <= '0;
        m_y <= (m_y == 10'(VT - 1)) ? 10'd0 : m_y + 10'd1;
      end else begin
        m_x <= m_x + 10'd1;
      end
    end
  end

  // Per-cycle coherency check against the model.
  always @(negedge clk) begin
    check("cyc_DrawX", int'(DrawX), int'(m_x));
    check("cyc_DrawY", int'(DrawY), int'(m_y));
    check("cyc_hs", int'(hs), int'(!(m_x >= 18 && m_x <= 21)));
    check("cyc_vs", int'(vs), int'(!(m_y >= 12 && m_y <= 13)));
    check("cyc_blank", int'(blank), int'(m_x < 16 && m_y < 10));
    check("cyc_frame_start", int'(frame_start), int'(m_fs));
  end

  // Advance (at negedges) until DUT is at (x, y); bounded to just over two frames.
  task automatic wait_at(input int x, input int y);
    int n;
    n = 0;
    while (!(int'(DrawX) == x && int'(DrawY) == y)) begin
      @(negedge clk);
      n++;
      if (n > 2 * FRAME + 5) begin
        check("wait_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic pulse_over();
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
  endtask

  // One full frame from (0,0): totals of blank, hs/vs low and pulse counts.
  task automatic measure_frame();
    int n_blank, n_hs, n_vs, n_hs_pulse, n_fs, vs_x, vs_y;
    logic prev_hs, prev_vs;
    n_blank = 0; n_hs = 0; n_vs = 0; n_hs_pulse = 0; n_fs = 0;
    vs_x = -1; vs_y = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    wait_at(0, 0);
    for (int i = 0; i < FRAME; i++) begin
      if (blank) n_blank++;
      if (!hs) n_hs++;
      if (!vs) n_vs++;
      if (frame_start) n_fs++;
      if (!hs && prev_hs) n_hs_pulse++;
      if (!vs && prev_vs && vs_y < 0) begin
        vs_x = int'(DrawX);
        vs_y = int'(DrawY);
      end
      prev_hs = hs;
      prev_vs = vs;
      @(negedge clk);
    end
    check("frame_blank_count", n_blank, 160);
    check("frame_hs_low_cycles", n_hs, 68);
    check("frame_hs_pulses", n_hs_pulse, 17);
    check("frame_vs_low_cycles", n_vs, 50);
    check("frame_vs_first_x", vs_x, 0);
    check("frame_vs_first_y", vs_y, 12);
    check("frame_fs_pulses", n_fs, 1);
  endtask

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic blank;
    logic fs;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int c;
    vecs[0]  = '{x: 0,  y: 0,  hs: 1, vs: 1, blank: 1, fs: 1};
    vecs[1]  = '{x: 16, y: 0,  hs: 1, vs: 1, blank: 0, fs: 0};
    vecs[2]  = '{x: 17, y: 3,  hs: 1, vs: 1, blank: 0, fs: 0};
    vecs[3]  = '{x: 18, y: 3,  hs: 0, vs: 1, blank: 0, fs: 0};
    vecs[4]  = '{x: 21, y: 3,  hs: 0, vs: 1, blank: 0, fs: 0};
    vecs[5]  = '{x: 22, y: 3,  hs: 1, vs: 1, blank: 0, fs: 0};
    vecs[6]  = '{x: 15, y: 9,  hs: 1, vs: 1, blank: 1, fs: 0};
    vecs[7]  = '{x: 0,  y: 10, hs: 1, vs: 1, blank: 0, fs: 0};
    vecs[8]  = '{x: 24, y: 11, hs: 1, vs: 1, blank: 0, fs: 0};
    vecs[9]  = '{x: 0,  y: 12, hs: 1, vs: 0, blank: 0, fs: 0};
    vecs[10] = '{x: 20, y: 12, hs: 0, vs: 0, blank: 0, fs: 0};
    vecs[11] = '{x: 5,  y: 13, hs: 1, vs: 0, blank: 0, fs: 0};
    vecs[12] = '{x: 5,  y: 14, hs: 1, vs: 1, blank: 0, fs: 0};
    vecs[13] = '{x: 24, y: 16, hs: 1, vs: 1, blank: 0, fs: 0};

    rst = 1'b1;
    start_btn = 1'b0;
    game_over = 1'b0;
    #1;
    check("rst_DrawX", int'(DrawX), 0);
    check("rst_DrawY", int'(DrawY), 0);
    check("rst_hs", int'(hs), 1);
    check("rst_vs", int'(vs), 1);
    check("rst_blank", int'(blank), 1);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_start_screen", int'(start_screen), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First frame_start arrives one full frame after release.
    c = 0;
    while (!frame_start && c < 2 * FRAME) begin
      @(negedge clk);
      c++;
    end
    check("first_fs_latency", c, FRAME);
    check("first_fs_DrawX", int'(DrawX), 0);
    check("first_fs_DrawY", int'(DrawY), 0);

    measure_frame();

    foreach (vecs[i]) begin
      wait_at(vecs[i].x, vecs[i].y);
      check($sformatf("vec%0d_hs", i), int'(hs), int'(vecs[i].hs));
      check($sformatf("vec%0d_vs", i), int'(vs), int'(vecs[i].vs));
      check($sformatf("vec%0d_blank", i), int'(blank), int'(vecs[i].blank));
      check($sformatf("vec%0d_fs", i), int'(frame_start), int'(vecs[i].fs));
    end

    // Mid-frame start pulse takes effect only at the next (0,0).
    wait_at(5, 3);
    pulse_start();
    check("s1_hold_mid", int'(start_screen), 1);
    wait_at(24, 16);
    check("s1_hold_last", int'(start_screen), 1);
    wait_at(0, 0);
    check("s1_play_at_00", int'(start_screen), 0);

    // game_over mid-frame returns to START at the next (0,0).
    wait_at(7, 5);
    pulse_over();
    wait_at(24, 16);
    check("s2_hold_last", int'(start_screen), 0);
    wait_at(0, 0);
    check("s2_start_at_00", int'(start_screen), 1);

    // start_btn only on the boundary clock itself.
    wait_at(24, 16);
    pulse_start();
    check("s3_play_at_00", int'(start_screen), 0);
    // Same-clock start pulse while in PLAY changes nothing.
    wait_at(24, 16);
    pulse_start();
    check("s3_play_kept", int'(start_screen), 0);

    // Both requests in one PLAY frame: game_over wins.
    wait_at(3, 2);
    pulse_start();
    wait_at(9, 4);
    pulse_over();
    wait_at(0, 0);
    check("s4_both_start", int'(start_screen), 1);
    // Latched start request must not leak into the next frame.
    wait_at(24, 16);
    @(negedge clk);
    check("s4_req_cleared", int'(start_screen), 1);

    // game_over in START is ignored and does not linger into PLAY.
    wait_at(2, 2);
    pulse_over();
    wait_at(0, 0);
    check("s5_over_ignored", int'(start_screen), 1);
    wait_at(2, 2);
    pulse_start();
    wait_at(0, 0);
    check("s5_play", int'(start_screen), 0);
    wait_at(24, 16);
    @(negedge clk);
    check("s5_over_cleared", int'(start_screen), 0);

    // Asynchronous reset mid-frame while in PLAY.
    wait_at(12, 8);
    rst = 1'b1;
    #1;
    check("mrst_DrawX", int'(DrawX), 0);
    check("mrst_DrawY", int'(DrawY), 0);
    check("mrst_hs", int'(hs), 1);
    check("mrst_vs", int'(vs), 1);
    check("mrst_blank", int'(blank), 1);
    check("mrst_frame_start", int'(frame_start), 0);
    check("mrst_start_screen", int'(start_screen), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_DrawX", int'(DrawX), 0);
    @(negedge clk);
    check("rel_step_DrawX", int'(DrawX), 1);
    check("rel_step_DrawY", int'(DrawY), 0);
    repeat (FRAME + 10) @(negedge clk);
    check("rel_start_screen", int'(start_screen), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
